// File: rtl/rr_arbiter_8x3.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant, its
// binary index, grant hold while the owner keeps requesting, and a fairness timeout.
module rr_arbiter_8x3 #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hold_cnt;

  // Scan from p upward with wrap-around; the MSB of the result flags a hit.
  function automatic logic [IDX_W:0] pick(input logic [N-1:0] r, input logic [IDX_W-1:0] p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] j;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = p + IDX_W'(k);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  logic [IDX_W-1:0] nxt_ptr;
  logic [IDX_W:0]   idle_pick, rel_pick, pre_pick;
  logic             timeout, others, owner_req;
  logic             load, drop, pre, ptr_upd;
  logic [IDX_W-1:0] new_idx;
  logic [N-1:0]     new_gnt;

  always_comb begin
    nxt_ptr   = gnt_idx + IDX_W'(1);
    owner_req = req[gnt_idx];
    others    = |(req & ~gnt);
    timeout   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
    idle_pick = pick(req, ptr);
    rel_pick  = pick(req, nxt_ptr);
    pre_pick  = pick(req & ~gnt, nxt_ptr);

    load    = 1'b0;
    drop    = 1'b0;
    pre     = 1'b0;
    ptr_upd = 1'b0;
    new_idx = '0;
    unique case (state)
      IDLE: begin
        if (idle_pick[IDX_W]) begin
          load    = 1'b1;
          new_idx = idle_pick[IDX_W-1:0];
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // Release: rotate past the owner and hand over on the same edge.
          ptr_upd = 1'b1;
          if (rel_pick[IDX_W]) begin
            load    = 1'b1;
            new_idx = rel_pick[IDX_W-1:0];
          end else begin
            drop = 1'b1;
          end
        end else if (timeout && others) begin
          ptr_upd = 1'b1;
          load    = 1'b1;
          pre     = 1'b1;
          new_idx = pre_pick[IDX_W-1:0];
        end
      end
      default: ;
    endcase

    new_gnt          = '0;
    new_gnt[new_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      preempt <= pre;
      if (ptr_upd) ptr <= nxt_ptr;
      if (load) begin
        state     <= GRANT;
        gnt       <= new_gnt;
        gnt_idx   <= new_idx;
        gnt_valid <= 1'b1;
        hold_cnt  <= 8'd1;
      end else if (drop) begin
        state     <= IDLE;
        gnt       <= '0;
        gnt_idx   <= '0;
        gnt_valid <= 1'b0;
        hold_cnt  <= '0;
      end else if (state == GRANT && !timeout && hold_cnt != 8'hFF) begin
        // Once at the limit the count parks there so a newcomer preempts at once.
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8x3.sv
// Directed scoreboard bench: stimulus queues the expected registered grant for the
// following cycle, a negedge monitor pops and compares.
module tb_rr_arbiter_8x3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] g;
    logic [2:0] i;
    logic       p;
    string      name;
  } exp_t;

  exp_t q[$];

  rr_arbiter_8x3 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .preempt(preempt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (gnt !== e.g || gnt_idx !== e.i || gnt_valid !== (e.g != 0) || preempt !== e.p) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got gnt=%b idx=%0d vld=%b pre=%b, want gnt=%b idx=%0d vld=%b pre=%b",
                   e.name, cyc, gnt, gnt_idx, gnt_valid, preempt, e.g, e.i, (e.g != 0), e.p);
        end
      end
    end
  end

  task automatic step(input logic [7:0] r, input logic [7:0] eg, input logic [2:0] ei,
                      input logic ep, input string name);
    exp_t e;
    e.cyc = cyc + 1; e.g = eg; e.i = ei; e.p = ep; e.name = name;
    q.push_back(e);
    req = r;
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== '0) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b pre=%b, want all zero",
               name, gnt, gnt_idx, gnt_valid, preempt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    req = '0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // 1: single request, one-cycle latency
    do_reset();
    step(8'h04, 8'h04, 3'd2, 1'b0, "t1_grant2");
    step(8'h00, 8'h00, 3'd0, 1'b0, "t1_release");
    step(8'h00, 8'h00, 3'd0, 1'b0, "t1_idle");

    // 2: everyone requesting, owner drops one cycle after its grant
    do_reset();
    step(8'hFF, 8'h01, 3'd0, 1'b0, "t2_first");
    for (int k = 0; k < 8; k++) begin
      logic [7:0] r;
      logic [7:0] g;
      r = ~(8'h01 << k);
      g = 8'h01 << ((k + 1) % 8);
      step(r, g, 3'((k + 1) % 8), 1'b0, "t2_rotate");
    end
    step(8'h00, 8'h00, 3'd0, 1'b0, "t2_idle");

    // 3: owner 7 releases, wrap to 0, then 1
    do_reset();
    step(8'h80, 8'h80, 3'd7, 1'b0, "t3_grant7");
    step(8'h03, 8'h01, 3'd0, 1'b0, "t3_wrap0");
    step(8'h02, 8'h02, 3'd1, 1'b0, "t3_next1");
    step(8'h00, 8'h00, 3'd0, 1'b0, "t3_idle");

    // 4: timeout preemption after 4 cycles
    do_reset();
    step(8'h08, 8'h08, 3'd3, 1'b0, "t4_hold1");
    step(8'h08, 8'h08, 3'd3, 1'b0, "t4_hold2");
    step(8'h28, 8'h08, 3'd3, 1'b0, "t4_hold3");
    step(8'h28, 8'h08, 3'd3, 1'b0, "t4_hold4");
    step(8'h28, 8'h20, 3'd5, 1'b1, "t4_preempt");
    step(8'h28, 8'h20, 3'd5, 1'b0, "t4_pulse_end");
    step(8'h08, 8'h08, 3'd3, 1'b0, "t4_back3");
    step(8'h00, 8'h00, 3'd0, 1'b0, "t4_idle");

    // 5: timeout with no competitor keeps the grant; newcomer preempts immediately
    do_reset();
    for (int k = 0; k < 20; k++) step(8'h08, 8'h08, 3'd3, 1'b0, "t5_hold");
    step(8'h48, 8'h40, 3'd6, 1'b1, "t5_preempt6");
    step(8'h00, 8'h00, 3'd0, 1'b0, "t5_idle");

    // 6: async reset between edges clears outputs immediately, ptr back to 0
    do_reset();
    step(8'hFF, 8'h01, 3'd0, 1'b0, "t6_grant0");
    step(8'hFE, 8'h02, 3'd1, 1'b0, "t6_grant1");
    step(8'hFD, 8'h04, 3'd2, 1'b0, "t6_grant2");
    @(negedge clk); #1;
    rst = 1'b1;
    #1 check_zero("t6_async_rst");
    req = 8'hFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(8'hFF, 8'h01, 3'd0, 1'b0, "t6_ptr_reset");
    step(8'h00, 8'h00, 3'd0, 1'b0, "t6_idle");

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
